// File: rtl/bcd_scheduler_pkg.sv
// rtl/bcd_scheduler_pkg.sv - shared widths, defaults and state encoding for bcd_scheduler
package bcd_scheduler_pkg;

    localparam int BIN_W        = 9;
    localparam int BCD_W        = 12;
    localparam int NREQ_DEFAULT = 4;

    // Encoding 2'd3 is deliberately unnamed; the FSM falls back to idle on it.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_scheduler_bcd.sv
// rtl/bcd_scheduler_bcd.sv - combinational 9-bit binary to 3-digit BCD converter
module bcd_scheduler_bcd
    import bcd_scheduler_pkg::*;
(
    input  logic [BIN_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    logic [BIN_W+BCD_W-1:0] sh;

    // Shift-and-add-3: correct each digit that would overflow before the next shift.
    always_comb begin
        sh = {{BCD_W{1'b0}}, din};
        for (int i = 0; i < BIN_W; i++) begin
            if (sh[BIN_W +: 4] >= 4'd5) begin
                sh[BIN_W +: 4] = sh[BIN_W +: 4] + 4'd3;
            end
            if (sh[BIN_W+4 +: 4] >= 4'd5) begin
                sh[BIN_W+4 +: 4] = sh[BIN_W+4 +: 4] + 4'd3;
            end
            if (sh[BIN_W+8 +: 4] >= 4'd5) begin
                sh[BIN_W+8 +: 4] = sh[BIN_W+8 +: 4] + 4'd3;
            end
            sh = sh << 1;
        end
    end

    assign dout = sh[BIN_W +: BCD_W];

endmodule

// File: rtl/bcd_scheduler.sv
// rtl/bcd_scheduler.sv - round-robin sharing of one BCD converter between requesters
module bcd_scheduler
    import bcd_scheduler_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [BIN_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BCD_W-1:0]      out_bcd,
    output logic [IDW-1:0]        out_id,
    output logic                  busy
);

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BIN_W-1:0]   din_q, din_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
    logic [IDW-1:0]     out_id_q, out_id_d;
    logic               out_valid_q, out_valid_d;

    logic [BCD_W-1:0]   conv_dout;
    logic [IDW:0]       pick;
    logic               win_found;
    logic [IDW-1:0]     win_idx;

    // First set bit at or above the pointer, wrapping; MSB of the result flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  p);
        logic           found;
        logic [IDW-1:0] w;
        int             j;
        found = 1'b0;
        w     = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(p) + k) % NREQ;
            if (!found && v[j]) begin
                found = 1'b1;
                w     = j[IDW-1:0];
            end
        end
        return {found, w};
    endfunction

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
        int n;
        n = (int'(id) + 1) % NREQ;
        return n[IDW-1:0];
    endfunction

    assign pick      = rr_pick(req_valid, rr_ptr_q);
    assign win_found = pick[IDW];
    assign win_idx   = pick[IDW-1:0];

    bcd_scheduler_bcd u_bcd (
        .din  (din_q),
        .dout (conv_dout)
    );

    // Next-state, grant and output-register decisions for the idle/convert/present loop.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        din_d       = din_q;
        id_d        = id_q;
        out_bcd_d   = out_bcd_q;
        out_id_d    = out_id_q;
        out_valid_d = out_valid_q;
        req_ready   = '0;
        case (state_q)
            S_IDLE: begin
                // Grant is suppressed under reset so no requester sees a phantom accept.
                if (win_found && !rst) begin
                    req_ready[win_idx] = 1'b1;
                    din_d              = req_data[win_idx*BIN_W +: BIN_W];
                    id_d               = win_idx;
                    state_d            = S_CONV;
                end
            end
            S_CONV: begin
                out_bcd_d   = conv_dout;
                out_id_d    = id_q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    rr_ptr_d    = next_ptr(out_id_q);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            din_q       <= '0;
            id_q        <= '0;
            out_bcd_q   <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            din_q       <= din_d;
            id_q        <= id_d;
            out_bcd_q   <= out_bcd_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign out_id    = out_id_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bcd_scheduler.sv
// tb/tb_bcd_scheduler.sv - self-checking bench for bcd_scheduler
module tb_bcd_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [35:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_bcd;
    logic [1:0]  out_id;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    int grant_log[$];
    int out_log[$];
    logic [3:0] seen_ready = '0;

    // reference model state
    bit          m_busy = 0;
    int          m_stage = 0;
    bit          m_ov = 0;
    int          m_ptr = 0;
    int          m_pv = 0;
    int          m_pid = 0;
    logic [11:0] m_bcd = '0;
    int          m_oid = 0;

    bcd_scheduler #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_id    (out_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int ref_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Every cycle: compare against the transaction model, log grants/outputs, advance the model.
    always @(negedge clk) begin
        logic [3:0] exp_rdy;
        int w;
        if (chk_en) begin
            exp_rdy = '0;
            w = -1;
            if (!m_busy && !rst) begin
                w = ref_pick(req_valid, m_ptr);
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (m_ov) begin
                chk("out_bcd", 32'(out_bcd), 32'(m_bcd));
                chk("out_id", 32'(out_id), 32'(m_oid));
            end
            for (int i = 0; i < 4; i++) if (req_ready[i]) grant_log.push_back(i);
            if (out_valid && out_ready) out_log.push_back(int'(out_id));
            seen_ready = req_ready;
            if (rst) begin
                m_busy = 0; m_stage = 0; m_ov = 0; m_ptr = 0;
            end else if (!m_busy) begin
                if (w >= 0) begin
                    m_busy = 1; m_stage = 1;
                    m_pv = int'(req_data[9*w +: 9]);
                    m_pid = w;
                end
            end else if (m_stage == 1) begin
                m_ov = 1; m_bcd = ref_bcd(m_pv); m_oid = m_pid; m_stage = 2;
            end else if (out_ready) begin
                m_ov = 0; m_ptr = (m_oid + 1) % 4; m_busy = 0; m_stage = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_valid = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) tick;
    endtask

    task automatic serve0(input int v, output logic [11:0] got);
        bit ok;
        got = '0;
        req_valid[0] = 1'b1;
        req_data[8:0] = 9'(v);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[0]) begin ok = 1; break; end
        end
        chk("serve0_grant", 32'(ok), 32'd1);
        tick;
        req_valid[0] = 1'b0;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; got = out_bcd; break; end
        end
        chk("serve0_out", 32'(ok), 32'd1);
        tick;
    endtask

    task automatic wait_grants(input int n);
        bit ok;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            tick;
            if (grant_log.size() >= n) begin ok = 1; break; end
        end
        chk("grant_wait", 32'(ok), 32'd1);
    endtask

    initial begin
        int          bv[6];
        logic [11:0] be[6];
        logic [11:0] got;
        logic [11:0] hold_bcd;
        logic [1:0]  hold_id;
        bit          ok;

        bv = '{0, 9, 10, 99, 100, 511};
        be = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h511};

        rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
        tick;
        chk_en = 1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bcd", 32'(out_bcd), 32'h0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);

        // single request from requester 2
        tick;
        req_valid = 4'b0100;
        req_data[26:18] = 9'd255;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'h4);
        tick;
        req_valid = '0;
        @(negedge clk);
        chk("t1_ov_n1", 32'(out_valid), 32'd0);
        tick;
        @(negedge clk);
        chk("t1_ov_n2", 32'(out_valid), 32'd1);
        chk("t1_bcd", 32'(out_bcd), 32'h255);
        chk("t1_id", 32'(out_id), 32'd2);
        tick;
        @(negedge clk);
        chk("t1_ov_n3", 32'(out_valid), 32'd0);
        tick;

        // boundary values and full sweep through requester 0
        do_reset;
        for (int i = 0; i < 6; i++) begin
            serve0(bv[i], got);
            chk("boundary_bcd", 32'(got), 32'(be[i]));
        end
        for (int v = 0; v < 512; v++) begin
            serve0(v, got);
            chk("sweep_bcd", 32'(got), 32'(ref_bcd(v)));
        end

        // all four requesters continuously valid
        do_reset;
        grant_log.delete();
        out_log.delete();
        for (int i = 0; i < 4; i++) req_data[9*i +: 9] = 9'($urandom_range(0, 511));
        req_valid = 4'hF;
        wait_grants(5);
        req_valid = '0;
        drain(6);
        if (grant_log.size() >= 5 && out_log.size() >= 4) begin
            chk("rr_g0", 32'(grant_log[0]), 32'd0);
            chk("rr_g1", 32'(grant_log[1]), 32'd1);
            chk("rr_g2", 32'(grant_log[2]), 32'd2);
            chk("rr_g3", 32'(grant_log[3]), 32'd3);
            chk("rr_g4", 32'(grant_log[4]), 32'd0);
            for (int i = 0; i < 4; i++) chk("rr_out_id", 32'(out_log[i]), 32'(i));
        end else begin
            chk("rr_log_size", 32'(grant_log.size()), 32'd5);
        end

        // backpressure
        do_reset;
        out_ready = 1'b0;
        req_valid = 4'b0010;
        req_data[17:9] = 9'd137;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[1]) begin ok = 1; break; end
        end
        chk("bp_grant", 32'(ok), 32'd1);
        tick;
        req_valid = 4'b1000;
        req_data[35:27] = 9'd300;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        chk("bp_out", 32'(ok), 32'd1);
        chk("bp_bcd", 32'(out_bcd), 32'h137);
        chk("bp_id", 32'(out_id), 32'd1);
        hold_bcd = out_bcd;
        hold_id = out_id;
        for (int k = 0; k < 5; k++) begin
            tick;
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_bcd", 32'(out_bcd), 32'(hold_bcd));
            chk("bp_hold_id", 32'(out_id), 32'(hold_id));
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        tick;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_ready", 32'(req_ready), 32'd0);
        tick;
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'h8);
        tick;
        req_valid = '0;
        drain(5);

        // fairness between requesters 0 and 3, late arrival at 1
        do_reset;
        grant_log.delete();
        req_data[8:0] = 9'd12;
        req_data[35:27] = 9'd480;
        req_valid = 4'b1001;
        wait_grants(4);
        wait_grants(5);
        req_valid[1] = 1'b1;
        req_data[17:9] = 9'd42;
        wait_grants(6);
        req_valid = '0;
        drain(6);
        if (grant_log.size() >= 6) begin
            chk("fair_g0", 32'(grant_log[0]), 32'd0);
            chk("fair_g1", 32'(grant_log[1]), 32'd3);
            chk("fair_g2", 32'(grant_log[2]), 32'd0);
            chk("fair_g3", 32'(grant_log[3]), 32'd3);
            chk("fair_g4", 32'(grant_log[4]), 32'd0);
            chk("fair_g5", 32'(grant_log[5]), 32'd1);
        end else begin
            chk("fair_log_size", 32'(grant_log.size()), 32'd6);
        end

        // reset while converting
        do_reset;
        out_log.delete();
        req_valid = 4'b0100;
        req_data[26:18] = 9'd77;
        @(negedge clk);
        chk("rc_grant", 32'(req_ready), 32'h4);
        tick;
        rst = 1'b1;
        @(negedge clk);
        chk("rc_conv_ov", 32'(out_valid), 32'd0);
        chk("rc_conv_busy", 32'(busy), 32'd1);
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("rc_busy", 32'(busy), 32'd0);
        chk("rc_ov", 32'(out_valid), 32'd0);
        chk("rc_regrant", 32'(req_ready), 32'h4);
        tick;
        req_valid = '0;
        drain(6);
        chk("rc_outputs", 32'(out_log.size()), 32'd1);

        // randomized traffic with backpressure and occasional reset
        do_reset;
        for (int c = 0; c < 3000; c++) begin
            tick;
            rst = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (seen_ready[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[9*i +: 9] = 9'($urandom_range(0, 511));
                end
            end
        end
        tick;
        rst = 1'b0;
        out_ready = 1'b1;
        req_valid = '0;
        drain(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
